// File: rtl/constellation_decoder.sv
// Receive-side slicer/demapper for the 5-bit lattice code: slices three soft samples,
// rebuilds the data word and flags low-confidence decisions, with saturating link counters.
module constellation_decoder #(
  parameter int unsigned BITS_WIDTH = 5,
  parameter int unsigned DIM0_WIDTH = 2,
  parameter int unsigned DIM1_WIDTH = 2,
  parameter int unsigned DIM2_WIDTH = 1,
  parameter int unsigned SOFT_WIDTH = 8,
  parameter int unsigned ERR_THRESH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [SOFT_WIDTH-1:0] r0,
  input  logic signed [SOFT_WIDTH-1:0] r1,
  input  logic signed [SOFT_WIDTH-1:0] r2,
  input  logic                         clr_cnt,
  output logic [BITS_WIDTH-1:0]        data,
  output logic                         out_valid,
  output logic                         low_conf,
  output logic [CNT_WIDTH-1:0]         sym_cnt,
  output logic [CNT_WIDTH-1:0]         lc_cnt
);

  // One extra bit so r - ideal can never overflow.
  localparam int unsigned EW  = SOFT_WIDTH + 1;
  localparam int unsigned AMP = 2 ** (SOFT_WIDTH - 3);

  localparam logic signed [EW-1:0] A1 = EW'(AMP);
  localparam logic signed [EW-1:0] A2 = EW'(2 * AMP);
  localparam logic signed [EW-1:0] A3 = EW'(3 * AMP);

  function automatic logic [DIM0_WIDTH-1:0] slice4(input logic signed [EW-1:0] r);
    logic [DIM0_WIDTH-1:0] idx;
    if (r < -A2) begin
      idx = DIM0_WIDTH'(0);
    end else if (r[EW-1]) begin
      idx = DIM0_WIDTH'(1);
    end else if (r < A2) begin
      idx = DIM0_WIDTH'(2);
    end else begin
      idx = DIM0_WIDTH'(3);
    end
    return idx;
  endfunction

  function automatic logic signed [EW-1:0] ideal4(input logic [DIM0_WIDTH-1:0] idx);
    logic signed [EW-1:0] v;
    unique case (idx)
      DIM0_WIDTH'(0): v = -A3;
      DIM0_WIDTH'(1): v = -A1;
      DIM0_WIDTH'(2): v = A1;
      default:        v = A3;
    endcase
    return v;
  endfunction

  function automatic logic [EW-1:0] abs_err(input logic signed [EW-1:0] r,
                                            input logic signed [EW-1:0] ideal);
    logic signed [EW-1:0] d;
    d = r - ideal;
    return d[EW-1] ? EW'(-d) : EW'(d);
  endfunction

  // Stage 1: input registers
  logic                         s1_valid_q;
  logic signed [SOFT_WIDTH-1:0] s1_r0_q;
  logic signed [SOFT_WIDTH-1:0] s1_r1_q;
  logic signed [SOFT_WIDTH-1:0] s1_r2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r0_q    <= '0;
      s1_r1_q    <= '0;
      s1_r2_q    <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_r0_q    <= r0;
      s1_r1_q    <= r1;
      s1_r2_q    <= r2;
    end
  end

  // Stage 2: slice and error magnitudes
  logic signed [EW-1:0]  r0_ext, r1_ext, r2_ext;
  logic [DIM0_WIDTH-1:0] x0_d;
  logic [DIM1_WIDTH-1:0] x1_d;
  logic [DIM2_WIDTH-1:0] x2_d;
  logic [EW-1:0]         e0_d, e1_d, e2_d;

  always_comb begin
    r0_ext = {s1_r0_q[SOFT_WIDTH-1], s1_r0_q};
    r1_ext = {s1_r1_q[SOFT_WIDTH-1], s1_r1_q};
    r2_ext = {s1_r2_q[SOFT_WIDTH-1], s1_r2_q};
    x0_d   = slice4(r0_ext);
    x1_d   = DIM1_WIDTH'(slice4(r1_ext));
    x2_d   = DIM2_WIDTH'(~r2_ext[EW-1]);
    e0_d   = abs_err(r0_ext, ideal4(x0_d));
    e1_d   = abs_err(r1_ext, ideal4(DIM0_WIDTH'(x1_d)));
    e2_d   = abs_err(r2_ext, r2_ext[EW-1] ? -A1 : A1);
  end

  logic                  s2_valid_q;
  logic [DIM0_WIDTH-1:0] s2_x0_q;
  logic [DIM1_WIDTH-1:0] s2_x1_q;
  logic [DIM2_WIDTH-1:0] s2_x2_q;
  logic [EW-1:0]         s2_e0_q, s2_e1_q, s2_e2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_x0_q    <= '0;
      s2_x1_q    <= '0;
      s2_x2_q    <= '0;
      s2_e0_q    <= '0;
      s2_e1_q    <= '0;
      s2_e2_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_x0_q    <= x0_d;
      s2_x1_q    <= x1_d;
      s2_x2_q    <= x2_d;
      s2_e0_q    <= e0_d;
      s2_e1_q    <= e1_d;
      s2_e2_q    <= e2_d;
    end
  end

  // Stage 3: threshold compare and demap
  logic                  low_d;
  logic [BITS_WIDTH-1:0] data_d;

  always_comb begin
    low_d  = (32'(s2_e0_q) > ERR_THRESH) || (32'(s2_e1_q) > ERR_THRESH) ||
             (32'(s2_e2_q) > ERR_THRESH);
    data_d = {s2_x0_q, s2_x1_q, s2_x2_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data      <= '0;
      low_conf  <= 1'b0;
    end else begin
      out_valid <= s2_valid_q;
      if (s2_valid_q) begin
        data     <= data_d;
        low_conf <= low_d;
      end
    end
  end

  // Counters step on the same edge that presents the symbol, so they track out_valid.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      sym_cnt <= '0;
      lc_cnt  <= '0;
    end else if (s2_valid_q) begin
      if (sym_cnt != '1) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
      if (low_d && (lc_cnt != '1)) begin
        lc_cnt <= lc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_constellation_decoder.sv
// Directed bench for constellation_decoder: default instance plus a 4-bit-counter instance
// sharing the same stimulus to exercise counter saturation.
`timescale 1ns / 1ps
module tb_constellation_decoder;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [7:0] r0, r1, r2;
  logic              clr_cnt;

  logic [4:0]  data, data_b;
  logic        out_valid, out_valid_b;
  logic        low_conf, low_conf_b;
  logic [15:0] sym_cnt, lc_cnt;
  logic [3:0]  sym_cnt_b, lc_cnt_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #1 clk = ~clk;

  constellation_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .r0(r0), .r1(r1), .r2(r2),
    .clr_cnt(clr_cnt), .data(data), .out_valid(out_valid), .low_conf(low_conf),
    .sym_cnt(sym_cnt), .lc_cnt(lc_cnt)
  );

  constellation_decoder #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .r0(r0), .r1(r1), .r2(r2),
    .clr_cnt(clr_cnt), .data(data_b), .out_valid(out_valid_b), .low_conf(low_conf_b),
    .sym_cnt(sym_cnt_b), .lc_cnt(lc_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pam4(input int x);
    return 8'((2 * x - 3) * 32);
  endfunction

  task automatic drive_code(input int code);
    r0 = pam4((code >> 3) & 3);
    r1 = pam4((code >> 1) & 3);
    r2 = (code & 1) ? 8'sd32 : -8'sd32;
    in_valid = 1'b1;
  endtask

  // Drive one sample, then wait until it is visible on the outputs.
  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    r0 = a; r1 = b; r2 = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  int tv_r0[6] = '{0, -1, 63, 64, -64, -65};
  int tv_x0[6] = '{2, 1, 2, 3, 1, 0};
  int exp_d;
  bit exp_ov;

  initial begin
    rst = 1'b1; in_valid = 1'b0; r0 = '0; r1 = '0; r2 = '0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_low_conf", low_conf, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_lc_cnt", lc_cnt, 0);
    rst = 1'b0;

    // All 32 ideal codes back to back.
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        chk("code_out_valid", out_valid, 1);
        chk("code_data", data, i - 3);
        chk("code_low_conf", low_conf, 0);
      end
      if (i < 32) drive_code(i);
      else in_valid = 1'b0;
    end
    chk("codes_sym_cnt", sym_cnt, 32);
    chk("codes_lc_cnt", lc_cnt, 0);
    chk("codes_sym_cnt_sat4", sym_cnt_b, 15);

    // Slicer thresholds.
    for (int k = 0; k < 6; k++) begin
      send1(8'(tv_r0[k]), 8'sd32, 8'sd32);
      chk("thresh_r0", data, tv_x0[k] * 8 + 5);
    end
    send1(8'sd32, 8'sd32, 8'sd0);
    chk("thresh_r2_zero", data, 21);
    send1(8'sd32, 8'sd32, -8'sd1);
    chk("thresh_r2_neg1", data, 20);

    // Confidence threshold.
    pulse_clr();
    chk("clr_sym_cnt", sym_cnt, 0);
    send1(8'sd48, 8'sd32, 8'sd32);
    chk("conf_48_data", data, 21);
    chk("conf_48_low", low_conf, 0);
    send1(8'sd49, 8'sd32, 8'sd32);
    chk("conf_49_low", low_conf, 1);
    send1(8'sd127, 8'sd32, 8'sd32);
    chk("conf_127_data", data, 29);
    chk("conf_127_low", low_conf, 1);
    chk("conf_lc_cnt", lc_cnt, 2);
    chk("conf_sym_cnt", sym_cnt, 3);

    // Bubbles: valid on even steps only; data must hold through gaps.
    pulse_clr();
    exp_d = 29;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_ov = (i >= 3) && (i - 3 < 8) && (((i - 3) % 2) == 0);
      if (exp_ov) exp_d = 3 * (i - 3) + 1;
      chk("bubble_out_valid", out_valid, exp_ov);
      chk("bubble_data", data, exp_d);
      if (i < 8 && (i % 2) == 0) drive_code(3 * i + 1);
      else in_valid = 1'b0;
    end
    chk("bubble_sym_cnt", sym_cnt, 4);

    // Saturation of the 4-bit counters; every symbol is low confidence.
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r0 = 8'sd127; r1 = 8'sd32; r2 = 8'sd32; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_sym_cnt", sym_cnt, 20);
    chk("sat_lc_cnt", lc_cnt, 20);
    chk("sat_sym_cnt4", sym_cnt_b, 15);
    chk("sat_lc_cnt4", lc_cnt_b, 15);

    // clr_cnt on an edge that also presents a valid symbol.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("clr_busy_out_valid", out_valid, 1);
        chk("clr_busy_sym_cnt", sym_cnt, 0);
        chk("clr_busy_lc_cnt", lc_cnt, 0);
        chk("clr_busy_sym_cnt4", sym_cnt_b, 0);
      end
      clr_cnt = (i == 4);
      r0 = 8'sd127; r1 = 8'sd32; r2 = 8'sd32; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_after_sym_cnt", sym_cnt, 3);
    chk("clr_after_lc_cnt", lc_cnt, 3);

    // Reset with three symbols in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_code(7 + 2 * i);
      if (i == 2) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_sym_cnt", sym_cnt, 0);
    chk("midrst_lc_cnt", lc_cnt, 0);
    chk("midrst_low_conf", low_conf, 0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_data", data, 0);
      @(negedge clk);
    end
    drive_code(22);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_ov_1", out_valid, 0);
    @(negedge clk);
    chk("post_rst_ov_2", out_valid, 0);
    @(negedge clk);
    chk("post_rst_ov_3", out_valid, 1);
    chk("post_rst_data", data, 22);
    chk("post_rst_sym_cnt", sym_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
